act_stream: RTL
===============

# act_stream

Parametrised activation streamer: fetches `cfg_len` words per bank from `NUM_BANKS` SRAM banks and issues reads under a credit limit. It buffers the returned data and presents it to the PE array as `LANES` elements per beat, optionally skewed by one beat per lane. It is the next-generation activation fetcher beside the weight fetcher in the STO block, and adds stride addressing, output back-pressure, a runtime skew mode and error detection.

## Interface
- `NUM_BANKS`, 4, SRAM banks read in lock-step
- `BANK_DW`, 64, bank read width (bits)
- `ADDR_W`, 15, bank address width
- `ELEM_W`, 8, element width; `LANES` = `NUM_BANKS*BANK_DW/ELEM_W` (derived, must be integral)
- `FIFO_DEPTH`, 4, return buffer words and max in-flight reads (≥2)
- `LEN_W`, 16, length counter width

Ports:
- `clk` in 1, sole clock
- `rst` in 1, synchronous, active-high reset
- `start` in 1, one-cycle launch pulse; ignored unless idle
- `cfg_base` in `ADDR_W`, first address (all banks)
- `cfg_stride` in `ADDR_W`, address increment per word
- `cfg_len` in `LEN_W`, words per bank; 0 = empty job
- `cfg_skew` in 1, 1 = lane l delayed l beats
- `busy` out 1, job in progress
- `done` out 1, one-cycle completion pulse
- `err` out 1, sticky; cleared by `rst` or accepted `start`
- `bce` out `NUM_BANKS`, bank read enables (all bits equal)
- `braddr` out `NUM_BANKS*ADDR_W`, bank b at `[b*ADDR_W +: ADDR_W]`
- `brdata` in `NUM_BANKS*BANK_DW`, returned data
- `brvalid` in `NUM_BANKS`, return strobes
- `out_valid` out 1 / `out_ready` in 1, valid-ready output handshake
- `out_data` out `LANES*ELEM_W`, lane l at `[l*ELEM_W +: ELEM_W]`
- `out_last` out 1, final beat of job

## Operation
- States: IDLE → FETCH on accepted `start`; FETCH → DRAIN when `cfg_len` reads have been issued; DRAIN → DONE when the final beat handshakes; DONE → IDLE after one cycle. `cfg_len`=0 goes IDLE → DONE directly with no reads and no output beats.
- Config is latched on the accepted `start`. Config changes mid-job have no effect.
- Address for word k = `cfg_base + k*cfg_stride` mod 2^`ADDR_W`. Wrap-around is legal and silent.
- Credit: `outstanding` = reads issued − words popped. A read issues (`bce` all 1) in FETCH only when `outstanding < FIFO_DEPTH`. The FIFO therefore never overflows.
- Return: a word is pushed when `brvalid[0]`=1. `err` sets if `brvalid` is not all-equal, or if `brvalid[0]` occurs in FETCH/DRAIN with `outstanding`=0. `brvalid` in IDLE is ignored and does not set `err`.
- Lane map: lane l = bank `l/(BANK_DW/ELEM_W)`, element `l%(BANK_DW/ELEM_W)`.
- Beats: total = `cfg_len + (cfg_skew ? LANES-1 : 0)`. On beat t, lane l carries word `t-l` (skew on) or word t (skew off). Lanes referencing a word before 0 or at/after `cfg_len` output 0.
- The pipeline advances only when `!out_valid || out_ready`. Skew registers hold during stall. A beat needing a FIFO word that is not yet available is not emitted, leaving a bubble. Zero-fill beats in the tail need no FIFO data.
- `out_last` = 1 with the final beat only.

## Timing
- Reset values: `busy`, `done`, `err`, `bce`, `out_valid`, `out_last` = 0; `braddr`, `out_data` = 0; all skew registers and counters = 0; state IDLE.
- `start` at cycle 0 → `busy`=1 and first `bce` at cycle 1. One read per cycle at most.
- `brvalid` at cycle t → word in FIFO at t+1 → popped into the output register, `out_valid` at t+2 if unstalled.
- Last beat handshake at cycle u → `done`=1 at u+1, `busy`=0 at u+2.
- `rst` mid-job: everything returns to reset values next cycle. In-flight returns are discarded.

## Structure
- Package `act_stream_pkg`: state enum (IDLE/FETCH/DRAIN/DONE) and the `LANES` derivation function.
- Sub-module `sto_fifo`: synchronous FIFO, width `NUM_BANKS*BANK_DW`, depth `FIFO_DEPTH`, with push/pop/empty/count.
- The skew array, credit counter, address generator and FSM are in the top module.

## Test plan
- Bench config NUM_BANKS=2, BANK_DW=16, ELEM_W=8 (LANES=4), FIFO_DEPTH=4, read latency 2:
- Skew on, `cfg_len`=3, words 0x0101…, `out_ready`=1 → 6 beats; beat 0 = {0,0,0,w0[0]}; beat 5 = {w2[3],0,0,0}; `out_last` on beat 5; `done` one cycle later.
- Skew off, `cfg_base`=0x7FFE, `cfg_stride`=1, `cfg_len`=4 → `braddr` sequence 0x7FFE, 0x7FFF, 0x0000, 0x0001; exactly 4 beats, each equal to its source word.
- `out_ready` held 0 for 10 cycles, `cfg_len`=8 → at most 4 reads outstanding; no data lost; beat order intact after release.
- `brvalid`=2'b01 on one return → `err`=1 and stays 1 until the next accepted `start`.
- `cfg_len`=0 → no `bce`, no `out_valid`; `done` pulses at cycle 1.
- `rst` asserted during DRAIN → all outputs 0 next cycle; a late `brvalid` in IDLE leaves `err`=0.

Source files
------------

// File: rtl/act_stream_pkg.sv
// Shared types for the activation streamer: FSM state encoding and the
// derivation of the output lane count from the bank geometry.
package act_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int lanes_of(input int num_banks, input int bank_dw, input int elem_w);
        return (num_banks * bank_dw) / elem_w;
    endfunction

endpackage

// File: rtl/sto_fifo.sv
// Return-data buffer: synchronous FIFO with a combinational head read so a
// word pushed at one edge can be popped in the very next cycle.
module sto_fifo #(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= next_ptr(wptr);
            if (do_pop)  rptr <= next_ptr(rptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/act_stream.sv
// Activation streamer: stride-addressed lock-step bank reads under a credit
// limit, buffered returns, and LANES-wide output beats with optional skew.
module act_stream
    import act_stream_pkg::*;
#(
    parameter int  NUM_BANKS  = 4,
    parameter int  BANK_DW    = 64,
    parameter int  ADDR_W     = 15,
    parameter int  ELEM_W     = 8,
    parameter int  FIFO_DEPTH = 4,
    parameter int  LEN_W      = 16,
    localparam int LANES      = lanes_of(NUM_BANKS, BANK_DW, ELEM_W)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [ADDR_W-1:0]             cfg_base,
    input  logic [ADDR_W-1:0]             cfg_stride,
    input  logic [LEN_W-1:0]              cfg_len,
    input  logic                          cfg_skew,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [NUM_BANKS-1:0]          bce,
    output logic [NUM_BANKS*ADDR_W-1:0]   braddr,
    input  logic [NUM_BANKS*BANK_DW-1:0]  brdata,
    input  logic [NUM_BANKS-1:0]          brvalid,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*ELEM_W-1:0]       out_data,
    output logic                          out_last
);

    localparam int WORD_W = NUM_BANKS * BANK_DW;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    state_t              state;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    issued;
    logic [ADDR_W-1:0]   stride_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                skew_q;
    logic [LEN_W:0]      total_q;
    logic [LEN_W:0]      beat;
    logic [CNT_W-1:0]    outstanding;

    logic                start_ok, active, issue, push, pop, step, adv;
    logic                need_word, beat_ok, last_hs, bad_ret, fifo_empty;
    logic [ADDR_W-1:0]   issue_addr, issue_stride;
    logic [CNT_W-1:0]    fifo_count;
    logic [WORD_W-1:0]   fifo_rdata, new_word;
    logic [LANES*ELEM_W-1:0] lane_skew;

    assign start_ok     = start && (state == IDLE);
    assign active       = (state == FETCH) || (state == DRAIN);
    // The launching start already issues word 0 so bce rises the next cycle.
    assign issue        = start_ok ? (cfg_len != '0)
                                   : ((state == FETCH) && (issued != len_q) &&
                                      (outstanding < CNT_W'(FIFO_DEPTH)));
    assign issue_addr   = start_ok ? cfg_base : addr_q;
    assign issue_stride = start_ok ? cfg_stride : stride_q;

    assign bad_ret = active && (((brvalid != '0) && (brvalid != '1)) ||
                                (brvalid[0] && (outstanding == '0)));
    assign push    = active && brvalid[0] && (outstanding != '0) &&
                     (fifo_count != CNT_W'(FIFO_DEPTH));

    assign adv       = !out_valid || out_ready;
    assign need_word = beat < {1'b0, len_q};
    assign beat_ok   = active && (beat < total_q) && (!need_word || !fifo_empty);
    assign step      = adv && beat_ok;
    assign pop       = step && need_word;
    assign new_word  = need_word ? fifo_rdata : '0;
    assign last_hs   = out_valid && out_ready && out_last;

    sto_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (brdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            bce         <= '0;
            braddr      <= '0;
            len_q       <= '0;
            stride_q    <= '0;
            skew_q      <= 1'b0;
            total_q     <= '0;
            addr_q      <= '0;
            issued      <= '0;
            outstanding <= '0;
        end else begin
            done        <= 1'b0;
            bce         <= {NUM_BANKS{issue}};
            outstanding <= outstanding + CNT_W'(issue) - CNT_W'(pop);
            if (bad_ret) err <= 1'b1;
            if (issue) begin
                braddr <= {NUM_BANKS{issue_addr}};
                addr_q <= issue_addr + issue_stride;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q    <= cfg_len;
                        stride_q <= cfg_stride;
                        skew_q   <= cfg_skew;
                        total_q  <= {1'b0, cfg_len} + (cfg_skew ? (LEN_W+1)'(LANES - 1) : '0);
                        issued   <= LEN_W'(issue);
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        if (cfg_len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (issue) issued <= issued + LEN_W'(1);
                    else if (issued == len_q) state <= DRAIN;
                    if (last_hs) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (last_hs) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output register stage: one beat per step, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            beat      <= '0;
        end else if (start_ok) begin
            beat <= '0;
        end else if (step) begin
            out_valid <= 1'b1;
            out_last  <= (beat == total_q - (LEN_W+1)'(1));
            out_data  <= skew_q ? lane_skew : new_word;
            beat      <= beat + (LEN_W+1)'(1);
        end else if (adv) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    // Lane l keeps the last l elements it was fed; the oldest is word t-l.
    assign lane_skew[ELEM_W-1:0] = new_word[ELEM_W-1:0];

    for (genvar l = 1; l < LANES; l++) begin : g_skew
        logic [l*ELEM_W-1:0] chain;

        always_ff @(posedge clk) begin
            if (rst || start_ok) begin
                chain <= '0;
            end else if (step) begin
                chain <= (chain << ELEM_W) | (l*ELEM_W)'(new_word[l*ELEM_W +: ELEM_W]);
            end
        end

        assign lane_skew[l*ELEM_W +: ELEM_W] = chain[(l-1)*ELEM_W +: ELEM_W];
    end

endmodule
